mem_arbiter: RTL

//   Shares the single-port synchronous RAM between the CPU memory path
//   (MAR/MDR Read/Write sequencing) and the DMA/program-loader port.
//   One transaction in flight at a time; round-robin on contention.

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every handshake and bus signal of the memory arbiter: the CPU
//   request port, the DMA/program-loader request port, the single-port RAM
//   port and the busy flag.
//   Modports:
//     slave  - the arbiter side (takes requests and ram_rdata, drives acks,
//              read data, the RAM strobe/address/data and busy)
//     master - the environment side (requesters plus the RAM itself)
//   Parameters:
//     ADDR_W  RAM word-address width
//     DATA_W  data width

interface mem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);

   // CPU memory path (MAR/MDR sequencing)
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   // DMA / program-loader port
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   // Single-port synchronous RAM
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter status
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ack, dma_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ack, dma_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata,
      input  busy
   );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous RAM between the CPU memory path and
//   the DMA/program-loader port. One access is in flight at a time; when
//   both ports request in the same IDLE cycle the port that did not win
//   last time is granted (round-robin). Each access is sequenced as
//   IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> DONE, and the winner gets a
//   one-cycle ack in DONE plus registered read data for reads.
//   Ports:
//     clk   system clock, all state on the rising edge
//     rst   synchronous active-high reset, abandons any in-flight access
//     bus   mem_arbiter_if.slave: CPU port, DMA port, RAM port, busy
//   Parameters:
//     ADDR_W  RAM word-address width (512 words by default)
//     DATA_W  data width
//     RD_LAT  RAM read latency in cycles, legal 1..4

module mem_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   state_t            state;
   owner_t            owner;
   owner_t            last_gnt;
   logic [CNT_W-1:0]  cnt;

   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              ram_en_q;
   logic              ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              busy_q;

   logic              grant_any;
   owner_t            grant_own;
   logic              gnt_we;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_wdata;

   // Arbitration decision, only acted on while IDLE. A tie goes to the
   // port that was not granted last, so sustained contention alternates.
   // Requests seen while busy are not remembered; the FSM simply does not
   // look at this logic outside IDLE.
   always_comb begin
      grant_any = bus.cpu_req | bus.dma_req;
      grant_own = OWN_CPU;
      if (bus.cpu_req && bus.dma_req) begin
         grant_own = (last_gnt == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (bus.dma_req) begin
         grant_own = OWN_DMA;
      end
      if (grant_own == OWN_DMA) begin
         gnt_we    = bus.dma_we;
         gnt_addr  = bus.dma_addr;
         gnt_wdata = bus.dma_wdata;
      end else begin
         gnt_we    = bus.cpu_we;
         gnt_addr  = bus.cpu_addr;
         gnt_wdata = bus.cpu_wdata;
      end
   end

   // Access sequencer. All outputs are registered here so that each one
   // changes exactly on the state transition it belongs to.
   // The ram_we/ram_addr/ram_wdata registers are loaded on the grant edge
   // and double as the latched copy of the winning request; ram_we_q is
   // still valid in ISSUE to decide between the write and read paths, and
   // all three are cleared when leaving ISSUE so the RAM bus reads zero
   // whenever ram_en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= OWN_CPU;
         last_gnt    <= OWN_DMA;
         cnt         <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner       <= grant_own;
                  last_gnt    <= grant_own;
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= gnt_we;
                  ram_addr_q  <= gnt_addr;
                  ram_wdata_q <= gnt_wdata;
                  busy_q      <= 1'b1;
                  state       <= ISSUE;
               end
            end

            ISSUE: begin
               ram_en_q    <= 1'b0;
               ram_we_q    <= 1'b0;
               ram_addr_q  <= '0;
               ram_wdata_q <= '0;
               if (ram_we_q) begin
                  cpu_ack_q <= (owner == OWN_CPU);
                  dma_ack_q <= (owner == OWN_DMA);
                  state     <= DONE;
               end else begin
                  cnt   <= CNT_W'(RD_LAT - 1);
                  state <= WAIT;
               end
            end

            // ram_rdata becomes valid RD_LAT cycles after ISSUE, which is
            // the WAIT cycle where cnt has reached zero.
            WAIT: begin
               if (cnt == '0) begin
                  if (owner == OWN_DMA) begin
                     dma_rdata_q <= bus.ram_rdata;
                  end else begin
                     cpu_rdata_q <= bus.ram_rdata;
                  end
                  cpu_ack_q <= (owner == OWN_CPU);
                  dma_ack_q <= (owner == OWN_DMA);
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            DONE: begin
               cpu_ack_q <= 1'b0;
               dma_ack_q <= 1'b0;
               busy_q    <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.busy      = busy_q;

   // Structural invariants of the sequencer
   a_single_ack: assert property (@(posedge clk) disable iff (rst)
      !(cpu_ack_q && dma_ack_q));
   a_en_in_issue: assert property (@(posedge clk) disable iff (rst)
      ram_en_q |-> (state == ISSUE));
   a_ack_in_done: assert property (@(posedge clk) disable iff (rst)
      (cpu_ack_q || dma_ack_q) |-> (state == DONE));

endmodule
